// File: rtl/tape_cell_reg_if.sv
// Data-memory handshake between the tape cell register (master) and data memory (slave).
interface tape_cell_reg_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 16
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/tape_cell_reg.sv
// Cached working cell of the BeeF datapath: single-cycle ALU writes, and a
// flush-then-fill memory handshake that stalls the core until the new cell is loaded.
module tape_cell_reg #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                write_enable,
   input  logic                write_src,
   input  logic [DW-1:0]       alu_data,
   input  logic [AW-1:0]       fill_addr,
   tape_cell_reg_if.master     mem,
   output logic [DW-1:0]       cell_value,
   output logic                cell_dirty,
   output logic                stall
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] cached_addr;
   logic [AW-1:0] pend_addr;
   logic          mem_start;
   logic          alu_write;

   assign mem_start = (state == IDLE) && write_enable && write_src;
   assign alu_write = (state == IDLE) && write_enable && !write_src;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Only IDLE accepts a request; FLUSH/FILL wait for ack, DONE retires the held instruction.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_start) begin
               state_nxt = cell_dirty ? FLUSH : FILL;
            end
         end
         FLUSH: begin
            if (mem.mem_ack) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (mem.mem_ack) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Bus outputs decode from state and registers only, so they hold steady while waiting.
   always_comb begin
      stall         = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state)
         IDLE: begin
            stall = mem_start;
         end
         FLUSH: begin
            stall         = 1'b1;
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = cached_addr;
            mem.mem_wdata = cell_value;
         end
         FILL: begin
            stall        = 1'b1;
            mem.mem_req  = 1'b1;
            mem.mem_addr = pend_addr;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cell_value  <= '0;
         cell_dirty  <= 1'b0;
         cached_addr <= '0;
         pend_addr   <= '0;
      end else begin
         if (alu_write) begin
            cell_value <= alu_data;
            cell_dirty <= 1'b1;
         end
         if (mem_start) begin
            pend_addr <= fill_addr;
         end
         if ((state == FLUSH) && mem.mem_ack) begin
            cell_dirty <= 1'b0;
         end
         if ((state == FILL) && mem.mem_ack) begin
            cell_value  <= mem.mem_rdata;
            cached_addr <= pend_addr;
            cell_dirty  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tape_cell_reg.sv
// Directed bench for tape_cell_reg: ALU-write vector table plus hand-timed memory sequences.
module tb_tape_cell_reg;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          write_enable;
   logic          write_src;
   logic [DW-1:0] alu_data;
   logic [AW-1:0] fill_addr;
   logic [DW-1:0] cell_value;
   logic          cell_dirty;
   logic          stall;

   tape_cell_reg_if #(.DW(DW), .AW(AW)) bus ();

   tape_cell_reg #(.DW(DW), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .write_src    (write_src),
      .alu_data     (alu_data),
      .fill_addr    (fill_addr),
      .mem          (bus.master),
      .cell_value   (cell_value),
      .cell_dirty   (cell_dirty),
      .stall        (stall)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int stall_cnt;

   typedef struct {
      logic          we;
      logic          src;
      logic [DW-1:0] alu;
      logic [DW-1:0] exp_value;
      logic          exp_dirty;
      logic          exp_stall;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic chk_bus(input string name, input logic req, input logic we, input logic [AW-1:0] addr);
      chk({name, ".req"},  32'(bus.mem_req),  32'(req));
      if (req) begin
         chk({name, ".we"},   32'(bus.mem_we),   32'(we));
         chk({name, ".addr"}, 32'(bus.mem_addr), 32'(addr));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      settle();
   endtask

   initial begin
      reset        = 1'b1;
      write_enable = 1'b0;
      write_src    = 1'b0;
      alu_data     = '0;
      fill_addr    = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;

      // Reset state
      do_reset();
      chk("rst.value", 32'(cell_value), 32'h0);
      chk("rst.dirty", 32'(cell_dirty), 32'h0);
      chk("rst.stall", 32'(stall), 32'h0);
      chk("rst.req",   32'(bus.mem_req), 32'h0);
      chk("rst.we",    32'(bus.mem_we), 32'h0);
      chk("rst.addr",  32'(bus.mem_addr), 32'h0);
      chk("rst.wdata", 32'(bus.mem_wdata), 32'h0);

      // ALU-write table: expected values are those seen one cycle after the vector is applied
      vecs[0] = '{we: 1'b1, src: 1'b0, alu: 8'h05, exp_value: 8'h05, exp_dirty: 1'b1, exp_stall: 1'b0};
      vecs[1] = '{we: 1'b0, src: 1'b0, alu: 8'hAA, exp_value: 8'h05, exp_dirty: 1'b1, exp_stall: 1'b0};
      vecs[2] = '{we: 1'b1, src: 1'b0, alu: 8'hFF, exp_value: 8'hFF, exp_dirty: 1'b1, exp_stall: 1'b0};
      vecs[3] = '{we: 1'b1, src: 1'b0, alu: 8'h00, exp_value: 8'h00, exp_dirty: 1'b1, exp_stall: 1'b0};
      vecs[4] = '{we: 1'b0, src: 1'b1, alu: 8'h33, exp_value: 8'h00, exp_dirty: 1'b1, exp_stall: 1'b0};
      vecs[5] = '{we: 1'b1, src: 1'b0, alu: 8'h5A, exp_value: 8'h5A, exp_dirty: 1'b1, exp_stall: 1'b0};
      for (int i = 0; i < 6; i++) begin
         tick();
         write_enable = vecs[i].we;
         write_src    = vecs[i].src;
         alu_data     = vecs[i].alu;
         settle();
         chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         tick();
         write_enable = 1'b0;
         write_src    = 1'b0;
         settle();
         chk($sformatf("vec%0d.value", i), 32'(cell_value), 32'(vecs[i].exp_value));
         chk($sformatf("vec%0d.dirty", i), 32'(cell_dirty), 32'(vecs[i].exp_dirty));
         chk($sformatf("vec%0d.req", i),   32'(bus.mem_req), 32'h0);
      end

      // Clean fill, ack on first FILL cycle: stall exactly 2 cycles
      do_reset();
      stall_cnt = 0;
      tick();
      write_enable = 1'b1;
      write_src    = 1'b1;
      fill_addr    = 16'h0010;
      settle();
      stall_cnt += int'(stall);
      chk("clean.idle_stall", 32'(stall), 32'h1);
      chk_bus("clean.idle", 1'b0, 1'b0, 16'h0);
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h2A;
      settle();
      stall_cnt += int'(stall);
      chk_bus("clean.fill", 1'b1, 1'b0, 16'h0010);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      stall_cnt += int'(stall);
      chk("clean.value", 32'(cell_value), 32'h2A);
      chk("clean.dirty", 32'(cell_dirty), 32'h0);
      chk_bus("clean.done", 1'b0, 1'b0, 16'h0);
      tick();
      write_enable = 1'b0;
      write_src    = 1'b0;
      settle();
      stall_cnt += int'(stall);
      chk("clean.stall_cycles", 32'(stall_cnt), 32'd2);
      chk_bus("clean.idle_after", 1'b0, 1'b0, 16'h0);

      // Dirty cell: flush 0x07@0x0010 strictly before fill @0x0011
      tick();
      write_enable = 1'b1;
      write_src    = 1'b0;
      alu_data     = 8'h07;
      tick();
      write_src = 1'b1;
      fill_addr = 16'h0011;
      settle();
      chk("dirty.pre_value", 32'(cell_value), 32'h07);
      chk("dirty.pre_dirty", 32'(cell_dirty), 32'h1);
      chk("dirty.idle_stall", 32'(stall), 32'h1);
      tick();
      bus.mem_ack = 1'b1;
      settle();
      chk_bus("dirty.flush", 1'b1, 1'b1, 16'h0010);
      chk("dirty.flush_wdata", 32'(bus.mem_wdata), 32'h07);
      chk("dirty.flush_stall", 32'(stall), 32'h1);
      tick();
      bus.mem_rdata = 8'h5C;
      settle();
      chk_bus("dirty.fill", 1'b1, 1'b0, 16'h0011);
      chk("dirty.fill_dirty", 32'(cell_dirty), 32'h0);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      chk("dirty.value", 32'(cell_value), 32'h5C);
      chk("dirty.done_stall", 32'(stall), 32'h0);
      tick();
      write_enable = 1'b0;
      write_src    = 1'b0;

      // FILL ack delayed 3 cycles: bus and stall hold, value loads only on ack
      tick();
      write_enable = 1'b1;
      write_src    = 1'b1;
      fill_addr    = 16'h0020;
      tick();
      fill_addr = 16'h00FF;
      for (int w = 0; w < 3; w++) begin
         settle();
         chk_bus($sformatf("wait%0d", w), 1'b1, 1'b0, 16'h0020);
         chk($sformatf("wait%0d.stall", w), 32'(stall), 32'h1);
         chk($sformatf("wait%0d.value", w), 32'(cell_value), 32'h5C);
         tick();
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h99;
      settle();
      chk_bus("wait.ack", 1'b1, 1'b0, 16'h0020);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      chk("wait.value", 32'(cell_value), 32'h99);
      chk("wait.done_req", 32'(bus.mem_req), 32'h0);
      tick();
      write_enable = 1'b0;
      write_src    = 1'b0;

      // Reset during FLUSH with ack pending, then a stray ack
      tick();
      write_enable = 1'b1;
      write_src    = 1'b0;
      alu_data     = 8'h44;
      tick();
      write_src = 1'b1;
      fill_addr = 16'h0030;
      tick();
      settle();
      chk_bus("rstmid.flush", 1'b1, 1'b1, 16'h0020);
      reset       = 1'b1;
      bus.mem_ack = 1'b1;
      tick();
      reset        = 1'b0;
      write_enable = 1'b0;
      write_src    = 1'b0;
      settle();
      chk("rstmid.req",   32'(bus.mem_req), 32'h0);
      chk("rstmid.value", 32'(cell_value), 32'h0);
      chk("rstmid.dirty", 32'(cell_dirty), 32'h0);
      chk("rstmid.stall", 32'(stall), 32'h0);
      tick();
      settle();
      chk("stray.req",   32'(bus.mem_req), 32'h0);
      chk("stray.value", 32'(cell_value), 32'h0);
      chk("stray.dirty", 32'(cell_dirty), 32'h0);
      bus.mem_ack = 1'b0;
      write_enable = 1'b1;
      alu_data     = 8'h11;
      tick();
      write_enable = 1'b0;
      settle();
      chk("rstmid.idle_inc", 32'(cell_value), 32'h11);

      // Back-to-back INC, MVR, INC; DONE must ignore the held write_enable
      write_enable = 1'b1;
      write_src    = 1'b0;
      alu_data     = 8'h12;
      tick();
      write_src = 1'b1;
      fill_addr = 16'h0040;
      settle();
      chk("b2b.inc1", 32'(cell_value), 32'h12);
      tick();
      bus.mem_ack = 1'b1;
      settle();
      chk_bus("b2b.flush", 1'b1, 1'b1, 16'h0000);
      chk("b2b.flush_wdata", 32'(bus.mem_wdata), 32'h12);
      tick();
      bus.mem_rdata = 8'h70;
      settle();
      chk_bus("b2b.fill", 1'b1, 1'b0, 16'h0040);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      chk("b2b.done_value", 32'(cell_value), 32'h70);
      chk("b2b.done_stall", 32'(stall), 32'h0);
      tick();
      write_src = 1'b0;
      alu_data  = 8'h71;
      settle();
      chk("b2b.no_rerun_req",   32'(bus.mem_req), 32'h0);
      chk("b2b.no_rerun_stall", 32'(stall), 32'h0);
      tick();
      write_enable = 1'b0;
      settle();
      chk("b2b.inc2_value", 32'(cell_value), 32'h71);
      chk("b2b.inc2_dirty", 32'(cell_dirty), 32'h1);
      chk("b2b.idle_req",   32'(bus.mem_req), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
